// File: rtl/wts_channel_scheduler.sv
// Six-phase time-division scheduler: one single-port wave RAM shared by five channel readers and the CPU port.
// Optional: WTS_SCC_SHARED_WAVE_EN lets channel 4 read bank 3 while scc_mode = 1.
module wts_channel_scheduler #(
    parameter int CH_NUM   = 5,
    parameter int FREQ_MIN = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH_NUM*12-1:0] ch_freq,
    input  logic [CH_NUM-1:0]    ch_key,
    input  logic [CH_NUM-1:0]    ch_ptr_reset,
    input  logic                 scc_mode,
    output logic [7:0]           ram_a,
    output logic                 ram_we,
    output logic [7:0]           ram_d,
    input  logic [7:0]           ram_q,
    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [7:0]           cpu_a,
    input  logic [7:0]           cpu_wdata,
    output logic                 cpu_ack,
    output logic [7:0]           cpu_rdata,
    output logic [CH_NUM*8-1:0]  ch_sample,
    output logic                 sample_valid
);

    localparam logic [2:0] CPU_PHASE = 3'd5;

    logic [2:0]        phase;
    logic [11:0]       freq   [CH_NUM];
    logic [11:0]       cnt    [CH_NUM];
    logic [4:0]        ptr    [CH_NUM];
    logic [7:0]        sample [CH_NUM];
    logic [CH_NUM-1:0] ptr_reset_pend;
    logic              ack_is_read;
    logic [2:0]        rd_bank;
    logic [4:0]        rd_index;

`ifdef WTS_SCC_SHARED_WAVE_EN
    // Channel 4 borrows bank 3 so both play the SCC shared waveform.
    always_comb rd_bank = (phase == 3'd4 && scc_mode) ? 3'd3 : phase;
`else
    logic unused_scc_mode;
    assign unused_scc_mode = scc_mode;
    always_comb rd_bank = phase;
`endif

    always_comb begin
        for (int n = 0; n < CH_NUM; n++) begin
            freq[n] = ch_freq[12*n +: 12];
        end
    end

    always_comb begin
        rd_index = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            if (phase == 3'(n)) rd_index = ptr[n];
        end
    end

    // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
    always_comb begin
        ram_a  = '0;
        ram_we = 1'b0;
        ram_d  = '0;
        if (phase == CPU_PHASE) begin
            if (cpu_req) begin
                ram_a  = cpu_a;
                ram_we = cpu_wr;
                ram_d  = cpu_wdata;
            end
        end else begin
            ram_a = {rd_bank, rd_index};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase          <= '0;
            ptr_reset_pend <= '0;
            sample_valid   <= 1'b0;
            cpu_ack        <= 1'b0;
            ack_is_read    <= 1'b0;
            // NOTE: these per-channel arrays are flip-flops, not RAM, so they can and must be reset.
            for (int n = 0; n < CH_NUM; n++) begin
                cnt[n]    <= '0;
                ptr[n]    <= '0;
                sample[n] <= '0;
            end
        end else begin
            phase        <= (phase == CPU_PHASE) ? 3'd0 : phase + 3'd1;
            sample_valid <= (phase == CPU_PHASE);
            cpu_ack      <= (phase == CPU_PHASE) && cpu_req;
            ack_is_read  <= (phase == CPU_PHASE) && cpu_req && !cpu_wr;

            // Read data for channel n returns one cycle after its address phase.
            for (int n = 0; n < CH_NUM; n++) begin
                if (phase == 3'(n + 1)) sample[n] <= ch_key[n] ? ram_q : 8'h00;
            end

            if (phase == CPU_PHASE) begin
                ptr_reset_pend <= '0;
                for (int n = 0; n < CH_NUM; n++) begin
                    if (ptr_reset_pend[n] || ch_ptr_reset[n]) begin
                        ptr[n] <= '0;
                        cnt[n] <= freq[n];
                    end else if (ch_key[n] && freq[n] >= 12'(FREQ_MIN)) begin
                        if (cnt[n] == '0) begin
                            cnt[n] <= freq[n];
                            ptr[n] <= ptr[n] + 5'd1;
                        end else begin
                            cnt[n] <= cnt[n] - 12'd1;
                        end
                    end
                end
            end else begin
                ptr_reset_pend <= ptr_reset_pend | ch_ptr_reset;
            end
        end
    end

    assign cpu_rdata = ack_is_read ? ram_q : 8'h00;

    always_comb begin
        ch_sample = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            ch_sample[8*n +: 8] = sample[n];
        end
    end

endmodule
